warp_sched_policy: RTL and testbench

- Parametrised next-generation warp scheduler front end; sits between warp control/branch resolution and the fetch stage.
- Holds per-warp active/stall/PC/thread-mask state.
- Selects one ready warp per cycle under a compile-time policy: fixed priority, round-robin, or greedy-then-lowest.
- Adds a starvation guard and a 2-entry registered output buffer toward fetch.

---
 rtl/warp_sched_policy.sv | 241 ++++++++++++++++++++++++
 tb/tb_warp_sched_policy.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_sched_policy.sv
// Warp scheduler front end: per-warp state, policy-based ready-warp selection, starvation
// guard and a 2-entry registered buffer toward fetch. Optional perf counters: SCHED_PERF_EN.
module warp_sched_policy #(
    parameter int unsigned NUM_WARPS     = 4,
    parameter int unsigned NUM_THREADS   = 4,
    parameter int unsigned PC_BITS       = 30,
    parameter int unsigned POLICY        = 1,
    parameter int unsigned STARVE_CYCLES = 64,
    localparam int unsigned WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_BITS-1:0]     startup_pc,
    input  logic                   spawn_valid,
    input  logic [NUM_WARPS-1:0]   spawn_wmask,
    input  logic [PC_BITS-1:0]     spawn_pc,
    input  logic                   tmc_valid,
    input  logic [WID_W-1:0]       tmc_wid,
    input  logic [NUM_THREADS-1:0] tmc_tmask,
    input  logic                   unlock_valid,
    input  logic [WID_W-1:0]       unlock_wid,
    input  logic                   br_valid,
    input  logic [WID_W-1:0]       br_wid,
    input  logic                   br_taken,
    input  logic [PC_BITS-1:0]     br_dest,
    output logic                   sched_valid,
    input  logic                   sched_ready,
    output logic [WID_W-1:0]       sched_wid,
    output logic [NUM_THREADS-1:0] sched_tmask,
    output logic [PC_BITS-1:0]     sched_pc,
    output logic [NUM_WARPS-1:0]   active_warps,
    output logic                   busy
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]            perf_idles,
    output logic [31:0]            perf_stalls,
    output logic [31:0]            perf_forced
`endif
);

    localparam int unsigned CNT_W = (STARVE_CYCLES > 0) ? $clog2(STARVE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_CYCLES);

    typedef struct packed {
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
    } entry_t;

    logic [NUM_WARPS-1:0]   active_q, active_d, stalled_q, stalled_d;
    logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_q [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_d [NUM_WARPS];
    logic [CNT_W-1:0]       starve_q [NUM_WARPS];
    logic [CNT_W-1:0]       starve_d [NUM_WARPS];
    logic [WID_W-1:0]       last_q, last_d;

    entry_t head_q, head_d, tail_q, tail_d, push_ent;
    logic   head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

    logic [NUM_WARPS-1:0] ready, starve_hit;
    logic [WID_W-1:0]     low_wid, pol_wid, rr_idx, force_wid, grant_wid;
    logic                 forced, grant, pop;

    assign ready = active_q & ~stalled_q;
    // A free slot exists whenever the tail entry is empty.
    assign grant = (|ready) && !tail_vld_q;
    assign pop   = head_vld_q && sched_ready;

    always_comb begin
        low_wid = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (ready[i]) low_wid = WID_W'(i);
        end
    end

    always_comb begin
        pol_wid = low_wid;
        rr_idx  = '0;
        case (POLICY)
            0: pol_wid = low_wid;
            1: begin
                // Descending scan so the nearest ready warp after last_q wins.
                for (int k = NUM_WARPS - 1; k >= 0; k--) begin
                    rr_idx = last_q + WID_W'(k + 1);
                    if (ready[rr_idx]) pol_wid = rr_idx;
                end
            end
            default: begin
                if (ready[last_q]) pol_wid = last_q;
            end
        endcase
    end

    always_comb begin
        starve_hit = '0;
        force_wid  = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            starve_hit[i] = (STARVE_CYCLES != 0) && ready[i] && (starve_q[i] == CNT_MAX);
        end
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (starve_hit[i]) force_wid = WID_W'(i);
        end
    end

    assign forced    = |starve_hit;
    assign grant_wid = forced ? force_wid : pol_wid;

    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            starve_d[i] = starve_q[i];
            if (STARVE_CYCLES == 0 || !ready[i] || (grant && grant_wid == WID_W'(i))) begin
                starve_d[i] = '0;
            end else if (starve_q[i] != CNT_MAX) begin
                starve_d[i] = starve_q[i] + CNT_W'(1);
            end
        end
    end

    // Warp state update; later sources override earlier ones.
    always_comb begin
        active_d  = active_q;
        stalled_d = stalled_q;
        tmask_d   = tmask_q;
        pc_d      = pc_q;
        last_d    = last_q;
        if (unlock_valid) stalled_d[unlock_wid] = 1'b0;
        if (br_valid) begin
            stalled_d[br_wid] = 1'b0;
            if (br_taken) pc_d[br_wid] = br_dest;
        end
        if (spawn_valid) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (spawn_wmask[i]) begin
                    active_d[i]  = 1'b1;
                    stalled_d[i] = 1'b0;
                    tmask_d[i]   = NUM_THREADS'(1);
                    pc_d[i]      = spawn_pc;
                end
            end
        end
        if (tmc_valid) begin
            tmask_d[tmc_wid]   = tmc_tmask;
            active_d[tmc_wid]  = |tmc_tmask;
            stalled_d[tmc_wid] = 1'b0;
        end
        if (grant) begin
            stalled_d[grant_wid] = 1'b1;
            last_d               = grant_wid;
            if (!(br_valid && br_taken && br_wid == grant_wid)) begin
                pc_d[grant_wid] = pc_q[grant_wid] + PC_BITS'(1);
            end
        end
    end

    always_comb begin
        push_ent   = '{wid: grant_wid, tmask: tmask_q[grant_wid], pc: pc_q[grant_wid]};
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        if (!head_vld_q) begin
            if (grant) begin
                head_d     = push_ent;
                head_vld_d = 1'b1;
            end
        end else if (pop) begin
            if (tail_vld_q) begin
                head_d = tail_q;
                if (grant) tail_d = push_ent;
                else       tail_vld_d = 1'b0;
            end else if (grant) begin
                head_d = push_ent;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (grant) begin
            tail_d     = push_ent;
            tail_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= NUM_WARPS'(1);
            stalled_q  <= '0;
            last_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                tmask_q[i]  <= '0;
                pc_q[i]     <= '0;
                starve_q[i] <= '0;
            end
            tmask_q[0] <= NUM_THREADS'(1);
            pc_q[0]    <= startup_pc;
        end else begin
            active_q   <= active_d;
            stalled_q  <= stalled_d;
            last_q     <= last_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            tmask_q    <= tmask_d;
            pc_q       <= pc_d;
            starve_q   <= starve_d;
        end
    end

    assign sched_valid  = head_vld_q;
    assign sched_wid    = head_q.wid;
    assign sched_tmask  = head_q.tmask;
    assign sched_pc     = head_q.pc;
    assign active_warps = active_q;
    assign busy         = (|active_q) || head_vld_q;

`ifdef SCHED_PERF_EN
    logic [31:0] idles_q, stalls_q, forced_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            idles_q  <= '0;
            stalls_q <= '0;
            forced_q <= '0;
        end else begin
            if (ready == '0)                 idles_q  <= idles_q + 32'd1;
            if (head_vld_q && !sched_ready)  stalls_q <= stalls_q + 32'd1;
            if (grant && forced)             forced_q <= forced_q + 32'd1;
        end
    end

    assign perf_idles  = idles_q;
    assign perf_stalls = stalls_q;
    assign perf_forced = forced_q;
`endif

endmodule

// File: tb/tb_warp_sched_policy.sv
// Bench for warp_sched_policy: a round-robin instance (a) and a greedy instance with an
// 8-cycle starvation guard (b); issued entries are compared against expected-entry queues.
module tb_warp_sched_policy;

    typedef struct packed {
        logic        reset;
        logic [29:0] startup_pc;
        logic        spawn_valid;
        logic [3:0]  spawn_wmask;
        logic [29:0] spawn_pc;
        logic        tmc_valid;
        logic [1:0]  tmc_wid;
        logic [3:0]  tmc_tmask;
        logic        unlock_valid;
        logic [1:0]  unlock_wid;
        logic        br_valid;
        logic [1:0]  br_wid;
        logic        br_taken;
        logic [29:0] br_dest;
        logic        sched_ready;
    } drv_t;

    typedef struct packed {
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [29:0] pc;
    } exp_t;

    logic clk;
    drv_t da, db;
    logic        a_valid, b_valid, a_busy, b_busy;
    logic [1:0]  a_wid, b_wid;
    logic [3:0]  a_tmask, b_tmask, a_active, b_active;
    logic [29:0] a_pc, b_pc;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_err = 0;

    warp_sched_policy #(.NUM_WARPS(4), .NUM_THREADS(4), .PC_BITS(30), .POLICY(1),
                        .STARVE_CYCLES(64)) u_rr (
        .clk(clk), .reset(da.reset), .startup_pc(da.startup_pc),
        .spawn_valid(da.spawn_valid), .spawn_wmask(da.spawn_wmask), .spawn_pc(da.spawn_pc),
        .tmc_valid(da.tmc_valid), .tmc_wid(da.tmc_wid), .tmc_tmask(da.tmc_tmask),
        .unlock_valid(da.unlock_valid), .unlock_wid(da.unlock_wid),
        .br_valid(da.br_valid), .br_wid(da.br_wid), .br_taken(da.br_taken),
        .br_dest(da.br_dest), .sched_valid(a_valid), .sched_ready(da.sched_ready),
        .sched_wid(a_wid), .sched_tmask(a_tmask), .sched_pc(a_pc),
        .active_warps(a_active), .busy(a_busy)
    );

    warp_sched_policy #(.NUM_WARPS(4), .NUM_THREADS(4), .PC_BITS(30), .POLICY(2),
                        .STARVE_CYCLES(8)) u_gr (
        .clk(clk), .reset(db.reset), .startup_pc(db.startup_pc),
        .spawn_valid(db.spawn_valid), .spawn_wmask(db.spawn_wmask), .spawn_pc(db.spawn_pc),
        .tmc_valid(db.tmc_valid), .tmc_wid(db.tmc_wid), .tmc_tmask(db.tmc_tmask),
        .unlock_valid(db.unlock_valid), .unlock_wid(db.unlock_wid),
        .br_valid(db.br_valid), .br_wid(db.br_wid), .br_taken(db.br_taken),
        .br_dest(db.br_dest), .sched_valid(b_valid), .sched_ready(db.sched_ready),
        .sched_wid(b_wid), .sched_tmask(b_tmask), .sched_pc(b_pc),
        .active_warps(b_active), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [1:0] w, input logic [3:0] t, input logic [29:0] p);
        exp_t e;
        e.wid = w; e.tmask = t; e.pc = p;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] w, input logic [3:0] t, input logic [29:0] p);
        exp_t e;
        e.wid = w; e.tmask = t; e.pc = p;
        exp_b.push_back(e);
    endtask

    task automatic drain_a(input string tag);
        int n;
        n = 0;
        while (exp_a.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        tick(3);
        check(tag, 64'(exp_a.size()), 64'd0);
    endtask

    task automatic drain_b(input string tag);
        int n;
        n = 0;
        while (exp_b.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        tick(3);
        check(tag, 64'(exp_b.size()), 64'd0);
    endtask

    // Scoreboard side: every accepted output entry is matched against the queue head.
    always @(negedge clk) begin
        if (!da.reset && a_valid && da.sched_ready) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_issue", 64'(exp_a.size()), 64'd1);
            end else begin
                ea = exp_a.pop_front();
                check("a_wid", 64'(a_wid), 64'(ea.wid));
                check("a_tmask", 64'(a_tmask), 64'(ea.tmask));
                check("a_pc", 64'(a_pc), 64'(ea.pc));
            end
        end
        if (!db.reset && b_valid && db.sched_ready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_issue", 64'(exp_b.size()), 64'd1);
            end else begin
                eb = exp_b.pop_front();
                check("b_wid", 64'(b_wid), 64'(eb.wid));
                check("b_tmask", 64'(b_tmask), 64'(eb.tmask));
                check("b_pc", 64'(b_pc), 64'(eb.pc));
            end
        end
    end

    // Greedy/starvation run: warps 0 and 3 ready behind a full buffer; first pop at Pu+pop_at.
    task automatic run_b(input int pop_at, input bit late);
        db.reset = 1'b1; db.sched_ready = 1'b0;
        tick(2);
        db.reset = 1'b0; db.spawn_valid = 1'b1; db.spawn_wmask = 4'b1000; db.spawn_pc = 30'h400;
        push_b(2'd0, 4'b0001, 30'h300);
        push_b(2'd3, 4'b0001, 30'h400);
        tick(1);
        db.spawn_valid = 1'b0;
        tick(2);
        db.unlock_valid = 1'b1; db.unlock_wid = 2'd0;
        db.br_valid = 1'b1; db.br_wid = 2'd3; db.br_taken = 1'b0;
        tick(1);
        db.unlock_valid = 1'b0; db.br_valid = 1'b0;
        check("b_full_valid", 64'(b_valid), 64'd1);
        check("b_full_head_wid", 64'(b_wid), 64'd0);
        check("b_active", 64'(b_active), 64'h9);
        tick(pop_at - 1);
        db.sched_ready = 1'b1;
        if (late) begin
            push_b(2'd0, 4'b0001, 30'h301);
            push_b(2'd3, 4'b0001, 30'h401);
        end else begin
            push_b(2'd3, 4'b0001, 30'h401);
            push_b(2'd0, 4'b0001, 30'h301);
        end
        drain_b(late ? "b_forced_drain" : "b_greedy_drain");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int wseq[7];
        wseq = '{0, 1, 2, 3, 0, 1, 2};
        da = '0; da.reset = 1'b1; da.sched_ready = 1'b1; da.startup_pc = 30'h100;
        db = '0; db.reset = 1'b1; db.startup_pc = 30'h300;
        tick(2);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_active", 64'(a_active), 64'h1);
        check("rst_busy", 64'(a_busy), 64'd1);
        check("rst_b_valid", 64'(b_valid), 64'd0);

        // Single warp: one issue, then nothing until unlocked.
        da.reset = 1'b0;
        push_a(2'd0, 4'b0001, 30'h100);
        tick(1);
        check("s1_first_valid", 64'(a_valid), 64'd1);
        tick(1);
        check("s1_stalled_idle", 64'(a_valid), 64'd0);
        tick(2);
        check("s1_still_idle", 64'(a_valid), 64'd0);
        da.unlock_valid = 1'b1; da.unlock_wid = 2'd0;
        push_a(2'd0, 4'b0001, 30'h101);
        tick(1);
        da.unlock_valid = 1'b0;
        drain_a("s1_drain");

        // Round-robin with spawn and per-grant unlocks.
        da.reset = 1'b1;
        tick(2);
        da.reset = 1'b0; da.spawn_valid = 1'b1; da.spawn_wmask = 4'b1110; da.spawn_pc = 30'h200;
        push_a(2'd0, 4'b0001, 30'h100);
        push_a(2'd1, 4'b0001, 30'h200);
        push_a(2'd2, 4'b0001, 30'h200);
        push_a(2'd3, 4'b0001, 30'h200);
        push_a(2'd0, 4'b0001, 30'h101);
        push_a(2'd1, 4'b0001, 30'h201);
        push_a(2'd2, 4'b0001, 30'h201);
        push_a(2'd3, 4'b0001, 30'h201);
        push_a(2'd0, 4'b0001, 30'h102);
        push_a(2'd1, 4'b0001, 30'h202);
        push_a(2'd2, 4'b0001, 30'h202);
        tick(1);
        da.spawn_valid = 1'b0;
        foreach (wseq[i]) begin
            da.unlock_valid = 1'b1; da.unlock_wid = 2'(wseq[i]);
            tick(1);
        end
        da.unlock_valid = 1'b0;
        check("s2_active", 64'(a_active), 64'hf);
        drain_a("s2_drain");

        // Backpressure: buffer holds two entries with stable head data.
        da.reset = 1'b1;
        tick(2);
        da.reset = 1'b0; da.sched_ready = 1'b0;
        da.spawn_valid = 1'b1; da.spawn_wmask = 4'b1110; da.spawn_pc = 30'h200;
        push_a(2'd0, 4'b0001, 30'h100);
        push_a(2'd1, 4'b0001, 30'h200);
        push_a(2'd2, 4'b0001, 30'h200);
        push_a(2'd3, 4'b0001, 30'h200);
        tick(1);
        da.spawn_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("s4_hold_valid", 64'(a_valid), 64'd1);
            check("s4_hold_wid", 64'(a_wid), 64'd0);
            check("s4_hold_pc", 64'(a_pc), 64'h100);
        end
        da.sched_ready = 1'b1;
        drain_a("s4_drain");

        // Branch resolution: taken redirects, not-taken keeps the advanced PC.
        da.br_valid = 1'b1; da.br_wid = 2'd1; da.br_taken = 1'b1; da.br_dest = 30'h340;
        push_a(2'd1, 4'b0001, 30'h340);
        tick(1);
        da.br_valid = 1'b0;
        drain_a("s5_taken_drain");
        da.br_valid = 1'b1; da.br_wid = 2'd1; da.br_taken = 1'b0; da.br_dest = 30'h3ff;
        push_a(2'd1, 4'b0001, 30'h341);
        tick(1);
        da.br_valid = 1'b0;
        drain_a("s5_not_taken_drain");

        // Thread-mask changes: activate warp 2, then deactivate everything.
        da.reset = 1'b1;
        tick(2);
        da.reset = 1'b0;
        push_a(2'd0, 4'b0001, 30'h100);
        tick(1);
        drain_a("s6_boot_drain");
        da.tmc_valid = 1'b1; da.tmc_wid = 2'd2; da.tmc_tmask = 4'b1010;
        push_a(2'd2, 4'b1010, 30'h0);
        tick(1);
        da.tmc_valid = 1'b0;
        check("s6_active_w2", 64'(a_active), 64'h5);
        drain_a("s6_tmc_drain");
        da.tmc_valid = 1'b1; da.tmc_wid = 2'd2; da.tmc_tmask = 4'b0000;
        tick(1);
        check("s6_active_w0", 64'(a_active), 64'h1);
        da.tmc_wid = 2'd0;
        tick(1);
        da.tmc_valid = 1'b0;
        check("s6_active_none", 64'(a_active), 64'h0);
        check("s6_busy", 64'(a_busy), 64'd0);

        run_b(7, 1'b0);
        run_b(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
